counter_ctrl: RTL

Synchronous count controller for the board-level counter/display path. It debounces three raw push-buttons and runs a STOP/RUN state machine. It generates a prescaled run tick and owns the WIDTH-bit count value that drives the LEDs and the hex display. It replaces direct button clocking of ripple flip-flops with a single-clock, glitch-free sequencer.

---
 rtl/counter_ctrl_pkg.sv | 18 +
 rtl/counter_ctrl_debounce.sv | 57 +++++
 rtl/counter_ctrl.sv | 99 +++++++++
 3 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared types and default parameters for the button-driven count controller.
package counter_ctrl_pkg;

   typedef enum logic [0:0] {
      STOP = 1'b0,
      RUN  = 1'b1
   } ctrl_state_t;

   localparam int DEF_WIDTH           = 4;
   localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
   localparam int DEF_TICK_DIV        = 50_000_000;

   localparam int NUM_BTNS  = 3;
   localparam int BTN_STEP  = 0;
   localparam int BTN_MODE  = 1;
   localparam int BTN_CLEAR = 2;

endpackage

// File: rtl/counter_ctrl_debounce.sv
// Button conditioner: 2-flop synchronizer, stability debouncer and a
// one-cycle pulse on each accepted rising level.
module btn_debounce
   import counter_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_i,
   output logic press_o
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic             level_q, level_d;
   logic             level_dly_q;
   logic             press_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // The counter only runs while the synchronized input disagrees with the
   // accepted level, so any bounce back to the accepted level restarts it.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         cnt_q       <= '0;
         level_q     <= 1'b0;
         level_dly_q <= 1'b0;
         press_q     <= 1'b0;
      end else begin
         sync1_q     <= btn_i;
         sync2_q     <= sync1_q;
         cnt_q       <= cnt_d;
         level_q     <= level_d;
         level_dly_q <= level_q;
         press_q     <= level_q & ~level_dly_q;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/counter_ctrl.sv
// STOP/RUN count sequencer: debounced buttons, prescaled run tick and the
// registered count, wrap strobe and display enable.
module counter_ctrl
   import counter_ctrl_pkg::*;
#(
   parameter int WIDTH           = DEF_WIDTH,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int TICK_DIV        = DEF_TICK_DIV
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             btn_step,
   input  logic             btn_mode,
   input  logic             btn_clear,
   output logic [WIDTH-1:0] count_out,
   output logic             run_active,
   output logic             wrap_pulse,
   output logic             display_en
);

   localparam int PRE_W = $clog2(TICK_DIV);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

   logic [NUM_BTNS-1:0] btn_raw;
   logic [NUM_BTNS-1:0] btn_press;

   assign btn_raw[BTN_STEP]  = btn_step;
   assign btn_raw[BTN_MODE]  = btn_mode;
   assign btn_raw[BTN_CLEAR] = btn_clear;

   generate
      for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
         btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_debounce (
            .clk    (clk),
            .rst_n  (rst_n),
            .btn_i  (btn_raw[gi]),
            .press_o(btn_press[gi])
         );
      end
   endgenerate

   ctrl_state_t      state_q, state_d;
   logic [PRE_W-1:0] presc_q, presc_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q, wrap_d;
   logic             disp_q;
   logic             tick;
   logic             incr;

   always_comb begin
      state_d = state_q;
      if (btn_press[BTN_MODE]) begin
         state_d = (state_q == STOP) ? RUN : STOP;
      end

      tick = (state_q == RUN) && (presc_q == PRE_LAST);
      incr = tick || ((state_q == STOP) && btn_press[BTN_STEP]);

      // The prescaler only advances while staying in RUN, so every entry
      // into RUN and every clear restarts a full tick period.
      presc_d = '0;
      if ((state_q == RUN) && (state_d == RUN) && !btn_press[BTN_CLEAR] && !tick) begin
         presc_d = presc_q + 1'b1;
      end

      count_d = count_q;
      wrap_d  = 1'b0;
      if (btn_press[BTN_CLEAR]) begin
         count_d = '0;
      end else if (incr) begin
         count_d = count_q + 1'b1;
         wrap_d  = (count_q == '1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= STOP;
         presc_q <= '0;
         count_q <= '0;
         wrap_q  <= 1'b0;
         disp_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         count_q <= count_d;
         wrap_q  <= wrap_d;
         disp_q  <= 1'b1;
      end
   end

   assign count_out  = count_q;
   assign run_active = (state_q == RUN);
   assign wrap_pulse = wrap_q;
   assign display_en = disp_q;

endmodule
